// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D unified memory arbiter.
// The optional perf counters are enabled with MEM_ARB_PERF_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The core's 2'b11 encoding has no meaning on the bus; it is sent as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : s;
  endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Grant and conflict counters for mem_arbiter.
// Instantiated only when MEM_ARB_PERF_EN is defined.
module mem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt_i,
  input  logic        gnt_d,
  input  logic        conflict,
  output logic [31:0] perf_i_cnt,
  output logic [31:0] perf_d_cnt,
  output logic [31:0] perf_conflict_cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_cnt        <= '0;
      perf_d_cnt        <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (gnt_i)    perf_i_cnt        <= perf_i_cnt + 32'd1;
      if (gnt_d)    perf_d_cnt        <= perf_d_cnt + 32'd1;
      if (conflict) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch (I) and load/store (D) onto one memory port, one transaction at a time.
// Define MEM_ARB_PERF_EN to add grant/conflict performance counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [1:0]    d_size,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [1:0]    m_size,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_i_cnt,
  output logic [31:0]   perf_d_cnt,
  output logic [31:0]   perf_conflict_cnt
`endif
);

  state_t        state;
  owner_t        owner;
  owner_t        last;
  logic [DW-1:0] i_hold;
  logic [DW-1:0] d_hold;
  logic          pickd;

  // D wins a conflict unless it was the one served last, so the two alternate.
  assign pickd = d_req && (!i_req || last == OWN_I);

  assign i_ack = !reset && state == RESP && m_rvalid && owner == OWN_I;
  assign d_ack = !reset && state == RESP && m_rvalid && owner == OWN_D;

  // Read data passes straight through on the ack cycle and is held afterwards.
  assign i_rdata = i_ack ? m_rdata : i_hold;
  assign d_rdata = (d_ack && !m_we) ? m_rdata : d_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_I;
      last    <= OWN_I;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_size  <= SZ_BYTE;
      i_hold  <= '0;
      d_hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pickd) begin
            m_addr  <= d_addr;
            m_we    <= d_we;
            m_wdata <= d_wdata;
            m_size  <= norm_size(d_size);
            owner   <= OWN_D;
            m_req   <= 1'b1;
            state   <= REQ;
          end else if (i_req) begin
            m_addr  <= i_addr;
            m_we    <= 1'b0;
            m_size  <= SZ_WORD;
            owner   <= OWN_I;
            m_req   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (m_gnt) begin
            m_req <= 1'b0;
            state <= RESP;
          end
        end
        RESP: begin
          if (m_rvalid) begin
            last  <= owner;
            state <= IDLE;
            if (owner == OWN_I)
              i_hold <= m_rdata;
            else if (!m_we)
              d_hold <= m_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic gnt_i;
  logic gnt_d;
  logic conflict;

  assign gnt_i    = state == REQ && m_gnt && owner == OWN_I;
  assign gnt_d    = state == REQ && m_gnt && owner == OWN_D;
  assign conflict = state == IDLE && i_req && d_req;

  mem_arb_perf u_perf (
    .clk               (clk),
    .reset             (reset),
    .gnt_i             (gnt_i),
    .gnt_d             (gnt_d),
    .conflict          (conflict),
    .perf_i_cnt        (perf_i_cnt),
    .perf_d_cnt        (perf_d_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a simple memory model, and an ack monitor.
// Perf counter checks are active when MEM_ARB_PERF_EN is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_size;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_cnt;
  logic [31:0] perf_d_cnt;
  logic [31:0] perf_conflict_cnt;
`endif

  typedef struct {
    bit          isd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   memen = 1'b1;
  int   gntwait = 0;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_size   (d_size),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_size   (m_size),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_i_cnt        (perf_i_cnt),
    .perf_d_cnt        (perf_d_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h0050_0093;
      32'h0000_0044: return 32'h00A0_0113;
      32'h0000_0100: return 32'h1111_2222;
      32'h0000_0104: return 32'h3333_4444;
      default:       return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  // Memory model: grant after gntwait request cycles, respond the cycle after the grant.
  initial begin : memmodel
    bit          pend;
    int          wcnt;
    logic [31:0] pdata;
    pend = 1'b0;
    wcnt = 0;
    pdata = '0;
    m_gnt = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
        wcnt = 0;
        if (memen) begin
          m_gnt = 1'b0;
          m_rvalid = 1'b0;
        end
      end else if (memen) begin
        m_gnt = 1'b0;
        m_rvalid = 1'b0;
        if (pend) begin
          m_rvalid = 1'b1;
          m_rdata = pdata;
          pend = 1'b0;
        end else if (m_req) begin
          if (wcnt >= gntwait) begin
            m_gnt = 1'b1;
            pend = 1'b1;
            wcnt = 0;
            pdata = m_we ? 32'hBAD0_0000 : memword(m_addr);
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // Monitor: every ack must match the oldest expected response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && (i_ack || d_ack)) begin
        total++;
        if (i_ack && d_ack) begin
          bad++;
          $display("[TB] FAIL dual_ack: got i_ack=%b d_ack=%b expected one", i_ack, d_ack);
        end else if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_ack: got i_ack=%b d_ack=%b expected none", i_ack, d_ack);
        end else begin
          e = sb.pop_front();
          if (e.isd != d_ack || (d_ack ? d_rdata : i_rdata) != e.data) begin
            bad++;
            $display("[TB] FAIL resp: got d=%b data=%h expected d=%b data=%h",
                     d_ack, d_ack ? d_rdata : i_rdata, e.isd, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input bit isd, input logic [31:0] data);
    exp_t e;
    e.isd = isd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise the requested lines and wait for nacks acks; hold keeps i_req up across acks.
  task automatic applyStimulus(input bit doi, input logic [31:0] iaddr,
                               input bit dod, input bit we, input logic [31:0] daddr,
                               input logic [31:0] wdata, input logic [1:0] size,
                               input int nacks, input bit hold, input bit chk,
                               output int lat);
    int start;
    int got;
    int prev;
    got = 0;
    prev = -1;
    lat = -1;
    @(negedge clk);
    start = cyc;
    if (doi) begin
      i_req = 1'b1;
      i_addr = iaddr;
    end
    if (dod) begin
      d_req = 1'b1;
      d_we = we;
      d_addr = daddr;
      d_wdata = wdata;
      d_size = size;
    end
    for (int c = 0; c < 80 && got < nacks; c++) begin
      @(negedge clk);
      #1;
      if (chk && m_req) begin
        checkOutput("hold_addr", m_addr, daddr);
        checkOutput("hold_we", {31'd0, m_we}, {31'd0, we});
        checkOutput("hold_wdata", m_wdata, wdata);
        checkOutput("hold_size", {30'd0, m_size}, {30'd0, size});
      end
      if (d_ack) begin
        d_req = 1'b0;
        got++;
      end
      if (i_ack) begin
        got++;
        if (hold) begin
          if (prev >= 0) checkOutput("b2b_gap", cyc - prev, 3);
          prev = cyc;
        end
        if (!hold || got >= nacks) i_req = 1'b0;
      end
      if (got >= nacks) lat = cyc - start;
    end
    if (got < nacks) begin
      checkOutput("ack_timeout", got, nacks);
      i_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    d_size = 2'b10;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_m_req", {31'd0, m_req}, 0);
    checkOutput("rst_m_we", {31'd0, m_we}, 0);
    checkOutput("rst_m_addr", m_addr, 0);
    checkOutput("rst_m_wdata", m_wdata, 0);
    checkOutput("rst_m_size", {30'd0, m_size}, 0);
    checkOutput("rst_acks", {30'd0, i_ack, d_ack}, 0);
    checkOutput("rst_i_rdata", i_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);

    // First conflict after reset goes to D, then I; the next conflict goes to D again.
    $display("[TB] conflict test");
    pushExp(1'b1, 32'h1111_2222);
    pushExp(1'b0, 32'h0050_0093);
    applyStimulus(1, 32'h40, 1, 0, 32'h100, 32'h0, 2'b10, 2, 0, 0, lat);
    pushExp(1'b1, 32'h3333_4444);
    pushExp(1'b0, 32'h00A0_0113);
    applyStimulus(1, 32'h44, 1, 0, 32'h104, 32'h0, 2'b10, 2, 0, 0, lat);
`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_conflict", perf_conflict_cnt, 2);
    checkOutput("perf_d", perf_d_cnt, 2);
    checkOutput("perf_i", perf_i_cnt, 2);
`endif

    $display("[TB] lone fetch");
    pushExp(1'b0, 32'h0050_0093);
    applyStimulus(1, 32'h40, 0, 0, 32'h0, 32'h0, 2'b10, 1, 0, 0, lat);
    checkOutput("lone_lat", lat, 2);

    $display("[TB] store with delayed grant");
    gntwait = 4;
    pushExp(1'b1, 32'h3333_4444);
    applyStimulus(0, 32'h0, 1, 1, 32'h200, 32'hDEAD_BEEF, 2'b01, 1, 0, 1, lat);
    checkOutput("store_lat", lat, 6);
    gntwait = 0;
    @(negedge clk);
    #1;
    checkOutput("store_rdata", d_rdata, 32'h3333_4444);

    $display("[TB] spurious response");
    @(negedge clk);
    memen = 1'b0;
    m_rvalid = 1'b1;
    m_rdata = 32'hFFFF_0000;
    #1;
    checkOutput("spur_idle_ack", {30'd0, i_ack, d_ack}, 0);
    @(negedge clk);
    m_rvalid = 1'b0;
    i_req = 1'b1;
    i_addr = 32'h44;
    @(negedge clk);
    m_rvalid = 1'b1;
    #1;
    checkOutput("spur_req_ack", {30'd0, i_ack, d_ack}, 0);
    checkOutput("spur_req_mreq", {31'd0, m_req}, 1);
    @(negedge clk);
    #1;
    checkOutput("spur_req_mreq2", {31'd0, m_req}, 1);
    checkOutput("spur_req_addr", m_addr, 32'h44);
    @(negedge clk);
    m_rvalid = 1'b0;
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    pushExp(1'b0, 32'h00A0_0113);
    m_rvalid = 1'b1;
    m_rdata = 32'h00A0_0113;
    #1;
    checkOutput("spur_real_ack", {31'd0, i_ack}, 1);
    i_req = 1'b0;
    @(negedge clk);
    m_rvalid = 1'b0;

    $display("[TB] reset mid-transaction");
    i_req = 1'b1;
    i_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    i_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_rvalid = 1'b1;
    m_rdata = 32'h1234_5678;
    #1;
    checkOutput("rst_mid_ack", {30'd0, i_ack, d_ack}, 0);
    checkOutput("rst_mid_mreq", {31'd0, m_req}, 0);
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    checkOutput("rst_mid_mreq2", {31'd0, m_req}, 0);
    checkOutput("rst_mid_rdata", i_rdata, 0);
    memen = 1'b1;
    pushExp(1'b0, 32'h0050_0093);
    applyStimulus(1, 32'h40, 0, 0, 32'h0, 32'h0, 2'b10, 1, 0, 0, lat);
    checkOutput("rst_mid_lat", lat, 2);

    $display("[TB] back-to-back fetches");
    doReset();
    for (int k = 0; k < 10; k++) pushExp(1'b0, 32'h0080_C0DE);
    applyStimulus(1, 32'h80, 0, 0, 32'h0, 32'h0, 2'b10, 10, 1, 0, lat);
    checkOutput("b2b_lat", lat, 29);
`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_i_b2b", perf_i_cnt, 10);
    checkOutput("perf_d_b2b", perf_d_cnt, 0);
    checkOutput("perf_conf_b2b", perf_conflict_cnt, 0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single unified memory port between the pipelined core's instruction-fetch requester (I) and its load/store requester (D).
- Sequences one outstanding memory transaction at a time using a req/gnt/rvalid handshake.
- Returns per-requester ack pulses. The hazard logic treats `!ack` as a fetch or memory stall.
- Sits between the core and the memory model/bus in the top level.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  AW  fetch address (PCF)
- i_rdata  out  DW  fetched instruction; valid when i_ack=1
- i_ack  out  1  one-cycle completion pulse for I
- d_req  in  1  load/store request; held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address (ALUResultM)
- d_wdata  in  DW  store data (WriteDataM)
- d_size  in  2  00 byte, 01 half, 10 word (ByteAccessM encoding); 11 is treated as word
- d_rdata  out  DW  load data; valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse for D
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  AW  memory address, registered
- m_wdata  out  DW  memory write data, registered
- m_size  out  2  memory access size, registered
- m_gnt  in  1  memory accepted the request this cycle (while m_req=1)
- m_rvalid  in  1  response: read data valid, or write complete
- m_rdata  in  DW  memory read data

Behaviour:
- States: IDLE, REQ, RESP. `owner` register is I or D. `last` register records the requester served last.
- Reset values: state=IDLE, owner=I, last=I, m_req=0, m_we=0, m_addr=0, m_wdata=0, m_size=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0.
- IDLE:
  - Only d_req, or both pending with last=I → latch the D fields into m_*, owner=D, go to REQ.
  - Only i_req, or both pending with last=D → latch m_addr=i_addr, m_we=0, m_size=10, owner=I, go to REQ.
  - No request → stay in IDLE.
- REQ:
  - m_req=1; all m_* fields are held stable.
  - m_gnt=1 → m_req=0 next cycle, go to RESP.
- RESP:
  - Wait for m_rvalid. On m_rvalid=1, pulse the owner's ack in the same cycle (combinational from m_rvalid & state=RESP & owner).
  - Drive the owner's rdata from m_rdata. rdata is registered-transparent: it holds the last value until the next ack.
  - Set last=owner and go to IDLE.
- Latency:
  - Request seen in cycle N → m_req=1 in N+1.
  - m_gnt=1 in N+1 → earliest m_rvalid and ack in N+2.
  - Minimum three cycles per transaction; one IDLE cycle between transactions.
- Fairness: when both are pending they alternate, so neither requester starves. The first conflict after reset serves D.
- Store ack: the D store gets d_ack on m_rvalid with d_rdata unchanged.
- m_rvalid while in IDLE or REQ: ignored; no ack is generated.
- m_gnt while not in REQ: ignored.
- Requester drops req before its ack (protocol violation): the transaction still completes and the ack still pulses; no abort.
- Reset mid-transaction: return to IDLE immediately and drop any pending memory response (its later m_rvalid is ignored per the IDLE rule).
- Both requests asserted in the same cycle as an m_rvalid: arbitration happens in the following IDLE cycle using the updated `last`.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds three outputs:
  - perf_i_cnt  out  32  I grants; increments on REQ→RESP when owner=I
  - perf_d_cnt  out  32  D grants; increments on REQ→RESP when owner=D
  - perf_conflict_cnt  out  32  IDLE cycles with i_req and d_req both asserted
- All three counters reset to 0 and wrap modulo 2^32.
- When undefined, the ports and logic are absent and the block is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, REQ, RESP}
  - owner enum {OWN_I, OWN_D}
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
- Sub-module mem_arb_perf holds the three counters. It is instantiated only under MEM_ARB_PERF_EN.

Test Plan:
- Lone fetch: i_req=1, i_addr=0x0000_0040, m_gnt=1 on first m_req cycle, m_rvalid next cycle with m_rdata=0x0050_0093 → i_ack pulses once, i_rdata=0x0050_0093, d_ack stays 0, total 3 cycles.
- Simultaneous requests after reset: i_req=d_req=1 (load, 0x100) → D served first, then I; next conflict serves D; perf_conflict_cnt=2 with MEM_ARB_PERF_EN.
- Store with delayed grant: d_we=1, d_addr=0x200, d_wdata=0xDEAD_BEEF, d_size=01, m_gnt held 0 for 4 cycles → m_* fields stable throughout; d_ack on m_rvalid; d_rdata unchanged.
- Spurious response: m_rvalid=1 while in IDLE and while in REQ → no ack; state unaffected.
- Reset mid-operation: assert reset in RESP, then deliver m_rvalid after reset → no ack, m_req=0, state=IDLE; a new i_req is then served normally.
- Back-to-back fetches: i_req held, memory with fixed 1-cycle grant and 1-cycle response → i_ack every 3 cycles; perf_i_cnt=10 after 10 acks.
